x_frame_streamer: RTL and testbench
===================================

// Module: x_frame_streamer
// PURPOSE
//  Transmit end of the x-sample valid/ready stream feeding conv_<LENX>_<LENF>_<WIDTH>_<P> engines.
//  Collects one frame of LENX signed samples from a load port, then streams it word-by-word on m_*_x.
//  Sits between a host/DMA source and the conv engine's s_data_in_x/s_valid_x/s_ready_x inputs.
// PARAMETERS
//  WIDTH  16             sample width (signed, two's complement)
//  LENX   64             samples per frame
//  ADDRX  $clog2(LENX)   buffer address width
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      asynchronous, active-low reset
//  ld_data_in    in   WIDTH  sample from source
//  ld_valid      in   1      ld_data_in valid
//  ld_ready      out  1      buffer can accept a sample
//  m_data_out_x  out  WIDTH  sample to conv engine
//  m_valid_x     out  1      m_data_out_x valid
//  m_ready_x     in   1      conv engine accepts sample
//  frame_done    out  1      1-cycle pulse, cycle after last word of a frame is accepted
//  busy          out  1      1 while any bank holds a full or partial frame
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0; fill/send addresses 0; state FILL; partial frames discarded.
//  - Load handshake: ld_valid&&ld_ready on clk edge writes ld_data_in at fill address, address+1.
//  - Send handshake: m_valid_x&&m_ready_x on clk edge consumes word at send address, address+1.
//  - FSM (single bank): FILL -> SEND when the LENX-th sample is written; SEND -> FILL on handshake of word LENX-1.
//  - FILL: ld_ready=1, m_valid_x=0. SEND: ld_ready=0, m_valid_x=1; ld_valid ignored.
//  - Latency: m_valid_x rises the cycle after the LENX-th load handshake, carrying word 0.
//  - m_data_out_x driven from buffer (combinational read of registered array at send address);
//    stable while m_valid_x=1 && m_ready_x=0; never changes without a handshake.
//  - Wrap: both addresses return to 0 after index LENX-1; no modular overflow beyond LENX-1.
//  - frame_done: registered, asserted exactly one cycle after final-word handshake.
//  - busy=1 from first load handshake until frame_done cycle (inclusive), else 0.
//  - Data passes unmodified; no arithmetic; sign preserved bit-exactly.
// CONFIGURATION
//  XSTREAM_PINGPONG_EN defined: two banks (A/B) with per-bank full flags; fill bank and send bank
//   pointers toggle independently. ld_ready=1 while fill bank not full; m_valid_x=1 while send bank full.
//   Last load into bank k and last send from bank k^1 in same cycle: both flags update, send pointer
//   moves to k, m_valid_x stays 1 next cycle (zero-bubble frame-to-frame). Both banks full: ld_ready=0.
//   Send bank empty while fill in progress: m_valid_x=0.
//  Undefined: single bank, FSM as above; load and send never overlap.
// STRUCTURE
//  Package xstream_pkg: state enum {FILL, SEND}; default WIDTH/LENX constants; bank index typedef.
//  Sub-module x_frame_bank: LENX x WIDTH register array, sync write, combinational read;
//   instantiated once, or twice under XSTREAM_PINGPONG_EN.
// TESTING
//  1 Reset, load 0..63, m_ready_x=1 -> outputs 0..63 consecutive; m_valid_x rises cycle after
//    64th load; frame_done one cycle after word 63 accepted.
//  2 Load -32768,32767,-1,... then m_ready_x random 50% -> each word once, in order, data stable while stalled.
//  3 Single bank, ld_valid held 1 throughout SEND -> ld_ready=0, no sample consumed until frame_done.
//  4 reset=0 asynchronously during SEND at word 20 -> m_valid_x, ld_ready 0 immediately; after release
//    new frame 100..163 loads and streams from word 0 (100).
//  5 XSTREAM_PINGPONG_EN, ld_valid=1, m_ready_x=1 continuously -> frame 2 word 0 follows frame 1 word 63
//    on next cycle; m_valid_x never drops after first frame.
//  6 9984 random words (156 frames), random ld_valid/m_ready_x -> output matches input sequence, 156 frame_done pulses.

Source files
------------

// File: rtl/x_frame_streamer_pkg.sv
// Shared types and default sizing for the x-sample frame streamer.
package xstream_pkg;

  localparam int unsigned XS_WIDTH = 16;
  localparam int unsigned XS_LENX  = 64;

  typedef enum logic {
    FILL,
    SEND
  } xs_state_e;

  typedef logic bank_idx_t;

endpackage

// File: rtl/x_frame_streamer_if.sv
// Load-side and conv-engine-side valid/ready signals of the x frame streamer.
interface x_frame_streamer_if
  import xstream_pkg::*;
#(
  parameter int unsigned WIDTH = XS_WIDTH
);
  logic [WIDTH-1:0] ld_data_in;
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] m_data_out_x;
  logic             m_valid_x;
  logic             m_ready_x;

  modport master (
    output ld_data_in, ld_valid, m_ready_x,
    input  ld_ready, m_data_out_x, m_valid_x
  );

  modport slave (
    input  ld_data_in, ld_valid, m_ready_x,
    output ld_ready, m_data_out_x, m_valid_x
  );
endinterface

// File: rtl/x_frame_streamer_bank.sv
// One frame of LENX samples: synchronous write, combinational read.
module x_frame_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENX  = 64,
  parameter int unsigned ADDRX = $clog2(LENX)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRX-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDRX-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [LENX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/x_frame_streamer.sv
// Collects one LENX-sample frame from the load port and streams it to a conv engine.
// XSTREAM_PINGPONG_EN: two banks so loading the next frame overlaps sending the current one.
module x_frame_streamer
  import xstream_pkg::*;
#(
  parameter int unsigned WIDTH = XS_WIDTH,
  parameter int unsigned LENX  = XS_LENX,
  parameter int unsigned ADDRX = $clog2(LENX)
) (
  input  logic                clk,
  input  logic                reset,
  x_frame_streamer_if.slave   xs,
  output logic                frame_done,
  output logic                busy
);
  localparam logic [ADDRX-1:0] LAST = ADDRX'(LENX - 1);

  logic             armed;
  logic             ld_rdy, m_vld;
  logic             ld_hs, send_hs;
  logic             fill_last, send_last;
  logic [ADDRX-1:0] fill_addr, send_addr;
  logic [WIDTH-1:0] rd_word;

  assign ld_hs     = xs.ld_valid && ld_rdy;
  assign send_hs   = m_vld && xs.m_ready_x;
  assign fill_last = (fill_addr == LAST);
  assign send_last = (send_addr == LAST);

  assign xs.ld_ready     = ld_rdy;
  assign xs.m_valid_x    = m_vld;
  // Gated so the bus reads 0 while idle and never follows fill writes.
  assign xs.m_data_out_x = m_vld ? rd_word : '0;

  // armed keeps ld_ready low while reset is held and for the first edge after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed      <= 1'b0;
      fill_addr  <= '0;
      send_addr  <= '0;
      frame_done <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (ld_hs)   fill_addr <= fill_last ? '0 : fill_addr + ADDRX'(1);
      if (send_hs) send_addr <= send_last ? '0 : send_addr + ADDRX'(1);
      frame_done <= send_hs && send_last;
    end
  end

`ifdef XSTREAM_PINGPONG_EN
  logic [1:0]       full, full_set, full_clr;
  bank_idx_t        fill_bank, send_bank;
  logic [WIDTH-1:0] rd_bank [2];

  // Set and clear always target different banks, so both may fire together.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (ld_hs && fill_last)   full_set[fill_bank] = 1'b1;
    if (send_hs && send_last) full_clr[send_bank] = 1'b1;
  end

  assign ld_rdy = armed && !full[fill_bank];
  assign m_vld  = full[send_bank];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full      <= '0;
      fill_bank <= '0;
      send_bank <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (ld_hs && fill_last)   fill_bank <= ~fill_bank;
      if (send_hs && send_last) send_bank <= ~send_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    x_frame_bank #(.WIDTH(WIDTH), .LENX(LENX), .ADDRX(ADDRX)) u_bank (
      .clk   (clk),
      .we    (ld_hs && (fill_bank == bank_idx_t'(b))),
      .waddr (fill_addr),
      .wdata (xs.ld_data_in),
      .raddr (send_addr),
      .rdata (rd_bank[b])
    );
  end

  assign rd_word = rd_bank[send_bank];
  assign busy    = (|full) || (fill_addr != '0) || frame_done;
`else
  xs_state_e state, state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_rdy    = 1'b0;
    m_vld     = 1'b0;
    unique case (state)
      FILL: begin
        ld_rdy = armed;
        if (armed && xs.ld_valid && fill_last) state_nxt = SEND;
      end
      SEND: begin
        m_vld = 1'b1;
        if (xs.m_ready_x && send_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  x_frame_bank #(.WIDTH(WIDTH), .LENX(LENX), .ADDRX(ADDRX)) u_bank (
    .clk   (clk),
    .we    (ld_hs),
    .waddr (fill_addr),
    .wdata (xs.ld_data_in),
    .raddr (send_addr),
    .rdata (rd_word)
  );

  assign busy = (state == SEND) || (fill_addr != '0) || frame_done;
`endif
endmodule

// File: tb/tb_x_frame_streamer.sv
// Randomized scoreboard bench for x_frame_streamer: output stream must equal the accepted input stream.
module tb_x_frame_streamer;
  import xstream_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned L = 64;
`ifdef XSTREAM_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_done, busy;

  x_frame_streamer_if #(.WIDTH(W)) xs_if ();

  x_frame_streamer #(.WIDTH(W), .LENX(L), .ADDRX($clog2(L))) dut (
    .clk        (clk),
    .reset      (rst_n),
    .xs         (xs_if),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, bad = 0;
  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  int unsigned ld_pct = 100, rdy_pct = 100;
  int unsigned loaded_words = 0, sent_words = 0, fd_cnt = 0;
  int unsigned lf, sf;
  bit fd_exp = 1'b0, fd_nxt = 1'b0, prev_stall = 1'b0, chk_rdy = 1'b0;
  logic [W-1:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames are complete after L accepted loads and leave in load order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      loaded_words = 0;
      sent_words   = 0;
      fd_exp       = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      lf = loaded_words / L;
      sf = sent_words / L;
      chk("m_valid_x", xs_if.m_valid_x, lf > sf);
      if (chk_rdy) chk("ld_ready", xs_if.ld_ready, PP ? ((lf - sf) < 2) : (lf == sf));
      chk("frame_done", frame_done, fd_exp);
      chk("busy", busy, ((loaded_words % L) != 0) || (lf > sf) || fd_exp);
      if (prev_stall) chk("stall_data", xs_if.m_data_out_x, prev_data);
      if (frame_done) fd_cnt++;
      fd_nxt = 1'b0;
      if (xs_if.m_valid_x && xs_if.m_ready_x) begin
        if (exp_q.size() == 0) chk("spurious_word", exp_q.size(), 1);
        else                   chk("data", xs_if.m_data_out_x, exp_q.pop_front());
        sent_words++;
        fd_nxt = ((sent_words % L) == 0);
      end
      prev_stall = xs_if.m_valid_x && !xs_if.m_ready_x;
      prev_data  = xs_if.m_data_out_x;
      if (xs_if.ld_valid && xs_if.ld_ready) begin
        exp_q.push_back(xs_if.ld_data_in);
        loaded_words++;
      end
      fd_exp = fd_nxt;
    end
  end

  // Load driver
  initial begin
    xs_if.ld_valid   = 1'b0;
    xs_if.ld_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || src_q.size() == 0) begin
        xs_if.ld_valid = 1'b0;
      end else if ($urandom_range(99) < ld_pct) begin
        xs_if.ld_valid   = 1'b1;
        xs_if.ld_data_in = src_q[0];
      end else begin
        xs_if.ld_valid   = 1'b0;
        xs_if.ld_data_in = W'($urandom);
      end
      @(negedge clk);
      if (rst_n && xs_if.ld_valid && xs_if.ld_ready) void'(src_q.pop_front());
    end
  end

  // Sink driver
  initial begin
    xs_if.m_ready_x = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      xs_if.m_ready_x = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || (loaded_words % L) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_rdy = 1'b1;
  endtask

  initial begin
    int unsigned n;
    int unsigned fd_base;

    #2;
    chk("rst_m_valid_x", xs_if.m_valid_x, 0);
    chk("rst_ld_ready", xs_if.ld_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", xs_if.m_data_out_x, 0);
    repeat (2) @(posedge clk);
    release_reset();

    // Ramp 0..63 at full throughput
    fd_base = fd_cnt;
    ld_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 64; i++) src_q.push_back(W'(i));
    drain(2000);
    chk("t1_frames", fd_cnt - fd_base, 1);

    // Extreme signed values with a stalling sink
    fd_base = fd_cnt;
    ld_pct = 80; rdy_pct = 50;
    src_q.push_back(16'h8000);
    src_q.push_back(16'h7FFF);
    src_q.push_back(16'hFFFF);
    for (int i = 3; i < 64; i++) src_q.push_back(W'($urandom));
    drain(3000);
    chk("t2_frames", fd_cnt - fd_base, 1);

    // ld_valid held high across the send phase
    fd_base = fd_cnt;
    ld_pct = 100; rdy_pct = 60;
    for (int i = 0; i < 128; i++) src_q.push_back(W'($urandom));
    drain(4000);
    chk("t3_frames", fd_cnt - fd_base, 2);

    // Asynchronous reset in the middle of a send
    ld_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 64; i++) src_q.push_back(W'($urandom));
    n = 0;
    while (sent_words < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reached_word20", n < 1000, 1);
    #2 rst_n = 1'b0;
    chk_rdy = 1'b0;
    src_q.delete();
    #1;
    chk("t4_m_valid_x", xs_if.m_valid_x, 0);
    chk("t4_ld_ready", xs_if.ld_ready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    release_reset();
    fd_base = fd_cnt;
    for (int i = 100; i < 164; i++) src_q.push_back(W'(i));
    drain(2000);
    chk("t4_frames", fd_cnt - fd_base, 1);

`ifdef XSTREAM_PINGPONG_EN
    // Continuous traffic: frames back to back with no bubble
    fd_base = fd_cnt;
    ld_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 256; i++) src_q.push_back(W'($urandom));
    drain(3000);
    chk("t5_frames", fd_cnt - fd_base, 4);
`endif

    // Long random soak
    fd_base = fd_cnt;
    ld_pct = 70; rdy_pct = 70;
    for (int i = 0; i < 9984; i++) src_q.push_back(W'($urandom));
    drain(60000);
    chk("t6_frames", fd_cnt - fd_base, 156);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
